// File: rtl/signed_temporal_dot_seq_pkg.sv
// Shared types and helpers for the sequenced temporal-slice dot-product engine.
package signed_temporal_dot_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  // Width of a slice-count field: max(1, clog2(max_prec / slice_w)).
  function automatic int nslice_w(input int max_prec, input int slice_w);
    int n;
    n = max_prec / slice_w;
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Extends a w-bit slice by one bit; sext selects sign- over zero-extension.
  function automatic logic [32:0] slice_ext(input logic [31:0] s, input int w, input logic sext);
    logic [32:0] mask;
    logic [32:0] r;
    mask = (33'd1 << w) - 33'd1;
    r    = {1'b0, s} & mask;
    if (sext && (((r >> (w - 1)) & 33'd1) != 33'd0))
      r = r | ~mask;
    return r;
  endfunction

endpackage

// File: rtl/temporal_slice_lane.sv
// One accumulator lane: selects and extends the current a/b slices, multiplies,
// shifts the product to its weight and accumulates it.
module temporal_slice_lane
  import signed_temporal_dot_seq_pkg::*;
#(
  parameter int A_WIDTH   = 2,
  parameter int B_WIDTH   = 2,
  parameter int MAX_A     = 8,
  parameter int MAX_B     = 8,
  parameter int ACC_WIDTH = 40,
  parameter int NA_W      = 2,
  parameter int NB_W      = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [MAX_A-1:0]     a_op,
  input  logic [MAX_B-1:0]     b_op,
  input  logic                 a_sign,
  input  logic                 b_sign,
  input  logic [NA_W-1:0]      i_idx,
  input  logic [NA_W-1:0]      a_top_idx,
  input  logic [NB_W-1:0]      j_idx,
  input  logic [NB_W-1:0]      b_top_idx,
  input  logic                 add_en,
  input  logic                 clr_en,
  output logic [ACC_WIDTH-1:0] acc
);

  logic [A_WIDTH-1:0]                a_slice;
  logic [B_WIDTH-1:0]                b_slice;
  logic signed [A_WIDTH:0]           a_ext;
  logic signed [B_WIDTH:0]           b_ext;
  logic signed [A_WIDTH+B_WIDTH+1:0] prod;
  logic signed [ACC_WIDTH-1:0]       term;
  int                                shamt;

  always_comb begin
    a_slice = A_WIDTH'(a_op >> (int'(i_idx) * A_WIDTH));
    b_slice = B_WIDTH'(b_op >> (int'(j_idx) * B_WIDTH));
    // Only the top active slice carries the sign; lower slices are magnitudes.
    a_ext   = (A_WIDTH+1)'(slice_ext(32'(a_slice), A_WIDTH, a_sign && (i_idx == a_top_idx)));
    b_ext   = (B_WIDTH+1)'(slice_ext(32'(b_slice), B_WIDTH, b_sign && (j_idx == b_top_idx)));
    prod    = a_ext * b_ext;
    shamt   = int'(i_idx) * A_WIDTH + int'(j_idx) * B_WIDTH;
    term    = ACC_WIDTH'(prod) << shamt;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!reset)      acc <= '0;
    else if (clr_en) acc <= '0;
    else if (add_en) acc <= acc + term;
  end

endmodule

// File: rtl/signed_temporal_dot_seq.sv
// Multi-lane signed/unsigned dot-product engine: sequences a/b slice pairs over
// NA*NB cycles per element and hands finished sums to a valid/ready output.
module signed_temporal_dot_seq
  import signed_temporal_dot_seq_pkg::*;
#(
  parameter int A_WIDTH   = 2,
  parameter int B_WIDTH   = 2,
  parameter int MAX_A     = 8,
  parameter int MAX_B     = 8,
  parameter int LANES     = 2,
  parameter int ACC_WIDTH = 40,
  localparam int NA_W     = nslice_w(MAX_A, A_WIDTH),
  localparam int NB_W     = nslice_w(MAX_B, B_WIDTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       a_sign_mode,
  input  logic                       b_sign_mode,
  input  logic [NA_W-1:0]            a_nslice_m1,
  input  logic [NB_W-1:0]            b_nslice_m1,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_last,
  input  logic [MAX_A-1:0]           a,
  input  logic [LANES*MAX_B-1:0]     b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*ACC_WIDTH-1:0] out
);

  state_t                     state, state_n;
  logic [NA_W-1:0]            i_cnt, i_n, a_nm1_r;
  logic [NB_W-1:0]            j_cnt, j_n, b_nm1_r;
  logic [MAX_A-1:0]           a_reg;
  logic [LANES*MAX_B-1:0]     b_reg;
  logic                       last_reg, a_sign_r, b_sign_r, cfg_fresh;
  logic                       accept, xfer, add_en, clr_en;
  logic [LANES*ACC_WIDTH-1:0] acc_all;

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n = state;
    i_n     = i_cnt;
    j_n     = j_cnt;
    accept  = 1'b0;
    xfer    = 1'b0;
    add_en  = 1'b0;
    clr_en  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept  = 1'b1;
          state_n = COMPUTE;
          i_n     = '0;
          j_n     = '0;
        end
      end
      COMPUTE: begin
        add_en = 1'b1;
        if (j_cnt == b_nm1_r) begin
          j_n = '0;
          if (i_cnt == a_nm1_r) begin
            i_n     = '0;
            state_n = last_reg ? FLUSH : IDLE;
          end else begin
            i_n = i_cnt + 1'b1;
          end
        end else begin
          j_n = j_cnt + 1'b1;
        end
      end
      FLUSH: begin
        if (!out_valid || out_ready) begin
          xfer    = 1'b1;
          clr_en  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      i_cnt     <= '0;
      j_cnt     <= '0;
      in_ready  <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      last_reg  <= 1'b0;
      a_sign_r  <= 1'b0;
      b_sign_r  <= 1'b0;
      a_nm1_r   <= '0;
      b_nm1_r   <= '0;
      cfg_fresh <= 1'b1;
      out_valid <= 1'b0;
      out       <= '0;
    end else begin
      state    <= state_n;
      i_cnt    <= i_n;
      j_cnt    <= j_n;
      in_ready <= (state_n == IDLE);
      if (accept) begin
        a_reg     <= a;
        b_reg     <= b;
        last_reg  <= in_last;
        cfg_fresh <= 1'b0;
        // Precision and signedness are fixed for the whole dot product.
        if (cfg_fresh) begin
          a_sign_r <= a_sign_mode;
          b_sign_r <= b_sign_mode;
          a_nm1_r  <= a_nslice_m1;
          b_nm1_r  <= b_nslice_m1;
        end
      end
      if (xfer) begin
        out       <= acc_all;
        out_valid <= 1'b1;
        cfg_fresh <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    temporal_slice_lane #(
      .A_WIDTH  (A_WIDTH),
      .B_WIDTH  (B_WIDTH),
      .MAX_A    (MAX_A),
      .MAX_B    (MAX_B),
      .ACC_WIDTH(ACC_WIDTH),
      .NA_W     (NA_W),
      .NB_W     (NB_W)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .a_op     (a_reg),
      .b_op     (b_reg[k*MAX_B +: MAX_B]),
      .a_sign   (a_sign_r),
      .b_sign   (b_sign_r),
      .i_idx    (i_cnt),
      .a_top_idx(a_nm1_r),
      .j_idx    (j_cnt),
      .b_top_idx(b_nm1_r),
      .add_en   (add_en),
      .clr_en   (clr_en),
      .acc      (acc_all[k*ACC_WIDTH +: ACC_WIDTH])
    );
  end

endmodule

// File: tb/tb_signed_temporal_dot_seq.sv
// Self-checking bench: integer-arithmetic dot-product model plus directed
// vectors with hand-computed results.
module tb_signed_temporal_dot_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_sign_mode, b_sign_mode;
  logic [1:0]  a_nslice_m1, b_nslice_m1;
  logic        in_valid, in_ready, in_last;
  logic [7:0]  a;
  logic [15:0] b;
  logic        out_valid, out_ready;
  logic [79:0] out;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [79:0] exp_q[$];
  longint      mdl_acc[2];
  bit          mdl_fresh;
  bit          m_as, m_bs;
  int          m_na, m_nb;
  logic        rst_prev = 1'b1;

  always #5 clk = ~clk;

  signed_temporal_dot_seq #(
    .A_WIDTH(2), .B_WIDTH(2), .MAX_A(8), .MAX_B(8), .LANES(2), .ACC_WIDTH(40)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .a_sign_mode(a_sign_mode),
    .b_sign_mode(b_sign_mode),
    .a_nslice_m1(a_nslice_m1),
    .b_nslice_m1(b_nslice_m1),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out)
  );

  task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic logic [79:0] pack2(input longint l0, input longint l1);
    return {l1[39:0], l0[39:0]};
  endfunction

  // Integer value of the low nbits of v, two's complement when sgn is set.
  function automatic longint field_val(input logic [7:0] v, input int nbits, input bit sgn);
    longint m;
    m = 0;
    for (int k = 0; k < nbits; k++)
      if (v[k]) m += (64'sd1 << k);
    if (sgn && v[nbits-1]) m -= (64'sd1 << nbits);
    return m;
  endfunction

  task automatic model_accept(input logic [7:0] av, input logic [15:0] bv, input logic last,
                              input logic asg, input logic bsg,
                              input logic [1:0] nam1, input logic [1:0] nbm1);
    longint aval;
    if (mdl_fresh) begin
      m_as = asg;
      m_bs = bsg;
      m_na = int'(nam1) + 1;
      m_nb = int'(nbm1) + 1;
      mdl_fresh = 1'b0;
    end
    aval = field_val(av, m_na * 2, m_as);
    for (int k = 0; k < 2; k++)
      mdl_acc[k] += aval * field_val(bv[k*8 +: 8], m_nb * 2, m_bs);
    if (last) begin
      exp_q.push_back(pack2(mdl_acc[0], mdl_acc[1]));
      mdl_acc[0] = 0;
      mdl_acc[1] = 0;
      mdl_fresh  = 1'b1;
    end
  endtask

  task automatic model_reset();
    mdl_acc[0] = 0;
    mdl_acc[1] = 0;
    mdl_fresh  = 1'b1;
    exp_q.delete();
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [7:0] av, input logic [7:0] b0, input logic [7:0] b1,
                      input logic last, input logic asg, input logic bsg,
                      input logic [1:0] nam1, input logic [1:0] nbm1);
    int waited;
    waited      = 0;
    a           = av;
    b           = {b1, b0};
    in_last     = last;
    a_sign_mode = asg;
    b_sign_mode = bsg;
    a_nslice_m1 = nam1;
    b_nslice_m1 = nbm1;
    in_valid    = 1'b1;
    while (!in_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", {79'd0, in_ready}, 80'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_accept(av, {b1, b0}, last, asg, bsg, nam1, nbm1);
  endtask

  // Cycle 0 is the accept cycle; returns the first cycle with out_valid high.
  task automatic wait_out_valid(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // Compare process: reset values, and every visible result against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && !rst_prev) begin
        check("reset_out_valid", {79'd0, out_valid}, 80'd0);
        check("reset_out", out, 80'd0);
        check("reset_in_ready", {79'd0, in_ready}, 80'd0);
      end else if (reset && out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", {79'd0, out_valid}, 80'd0);
        end else begin
          check("out_vs_model", out, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      rst_prev = reset;
    end
  end

  initial begin
    int cyc;
    reset       = 1'b0;
    in_valid    = 1'b0;
    in_last     = 1'b0;
    out_ready   = 1'b1;
    a           = '0;
    b           = '0;
    a_sign_mode = 1'b0;
    b_sign_mode = 1'b0;
    a_nslice_m1 = 2'd3;
    b_nslice_m1 = 2'd3;
    model_reset();
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_reset", {79'd0, in_ready}, 80'd1);

    // Full-precision signed: -3*5 and -3*-7.
    send(8'hFD, 8'h05, 8'hF9, 1'b1, 1'b1, 1'b1, 2'd3, 2'd3);
    wait_out_valid(cyc);
    check("full_latency", 80'(cyc), 80'd18);
    check("full_signed_literal", out, pack2(-15, 21));
    @(posedge clk); #1;
    check("out_valid_drops", {79'd0, out_valid}, 80'd0);

    // Unsigned maximum.
    send(8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 2'd3, 2'd3);
    wait_out_valid(cyc);
    check("unsigned_max_literal", out, pack2(65025, 65025));

    // Reduced precision: 4-bit a, 2-bit b; upper operand bits ignored.
    @(posedge clk); #1;
    send(8'hA7, 8'h03, 8'h01, 1'b1, 1'b1, 1'b1, 2'd1, 2'd0);
    wait_out_valid(cyc);
    check("reduced_latency", 80'(cyc), 80'd4);
    check("reduced_literal", out, pack2(-7, 7));

    // Three-element dot product with gaps; config on elements 2-3 is ignored.
    @(posedge clk); #1;
    send(8'd3, 8'd4, 8'd1, 1'b0, 1'b1, 1'b1, 2'd3, 2'd3);
    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    send(8'hFE, 8'd5, 8'd2, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    send(8'd7, 8'hFF, 8'd3, 1'b1, 1'b0, 1'b1, 2'd1, 2'd0);
    wait_out_valid(cyc);
    check("dot_product_literal", out, pack2(-5, 20));

    // Backpressure: second result stalls in FLUSH behind the first.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(8'd10, 8'd3, 8'hFE, 1'b1, 1'b1, 1'b1, 2'd3, 2'd3);
    wait_out_valid(cyc);
    check("bp_first_literal", out, pack2(30, -20));
    send(8'd5, 8'd5, 8'd1, 1'b1, 1'b1, 1'b1, 2'd3, 2'd3);
    repeat (20) begin @(posedge clk); #1; end
    check("bp_in_ready_low", {79'd0, in_ready}, 80'd0);
    check("bp_out_valid_held", {79'd0, out_valid}, 80'd1);
    check("bp_first_stable", out, pack2(30, -20));
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_second_valid", {79'd0, out_valid}, 80'd1);
    check("bp_second_literal", out, pack2(25, 5));
    @(posedge clk); #1;
    check("bp_drained", {79'd0, out_valid}, 80'd0);

    // Reset in the middle of a partial sum.
    send(8'h7F, 8'h33, 8'h22, 1'b0, 1'b1, 1'b1, 2'd3, 2'd3);
    repeat (5) begin @(posedge clk); #1; end
    reset = 1'b0;
    model_reset();
    repeat (3) begin @(posedge clk); #1; end
    check("mid_reset_out", out, 80'd0);
    check("mid_reset_in_ready", {79'd0, in_ready}, 80'd0);
    reset = 1'b1;
    send(8'd1, 8'd1, 8'd1, 1'b1, 1'b1, 1'b1, 2'd3, 2'd3);
    wait_out_valid(cyc);
    check("post_reset_literal", out, pack2(1, 1));
    repeat (3) begin @(posedge clk); #1; end
    check("model_queue_drained", 80'(exp_q.size()), 80'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
